// File: rtl/uart_rx_frontend_if.sv
// Word handoff between the UART receive front end (master) and the receive FIFO (slave).
interface uart_rx_frontend_if #(
    parameter int DATA_ = 8
);
    logic [DATA_-1:0] dout;
    logic             valid;
    logic             ready;
    logic             parity_err;
    logic             frame_err;
    logic             brk;
    logic             overrun;

    modport master (
        output dout, valid, parity_err, frame_err, brk, overrun,
        input  ready
    );

    modport slave (
        input  dout, valid, parity_err, frame_err, brk, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-FF sync, 3-sample majority vote, parity/frame/break/overrun checks.
// Latency: valid rises on the edge closing the last stop-bit decision cycle, 3 clocks after the line-level decision point.
module uart_rx_frontend #(
    parameter int F_CLK    = 50000000,
    parameter int BAUDRATE = 2000000,
    parameter int DATA_    = 8,
    parameter int STOP_    = 1,
    parameter int PARITY   = 0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               rx,
    output logic               busy,
    uart_rx_frontend_if.master bus
);
    localparam int BIT_     = F_CLK / BAUDRATE;
    localparam int HALF     = BIT_ / 2;
    localparam int CNT_W    = $clog2(BIT_);
    localparam int BITS_MAX = (DATA_ > STOP_) ? DATA_ : STOP_;
    localparam int IDX_W    = $clog2(BITS_MAX);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               s0_q, s0_d, s1_q, s1_d;
    logic               stop_err_q, stop_err_d;
    logic               stop_low_q, stop_low_d;
    logic               wait_high_q, wait_high_d;
    logic [DATA_-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, ovr_q, ovr_d;

    logic rxs, decide, vote, done, last_data, last_stop;
    logic word_perr, word_ferr, word_brk;

    assign rxs       = sync_q[1];
    assign decide    = (cnt_q == CNT_W'(HALF + 1));
    assign vote      = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign last_data = (idx_q == IDX_W'(DATA_ - 1));
    assign last_stop = (idx_q == IDX_W'(STOP_ - 1));

    // NOTE: sequential state uses non-blocking assignments only; all logic lives in always_comb.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (!wait_high_q && !rxs) state_d = START;
            START: if (decide) state_d = vote ? IDLE : DATA;
            DATA:  if (decide && last_data) state_d = (PARITY != 0) ? PAR : STOP;
            PAR:   if (decide) state_d = STOP;
            STOP:  if (decide && last_stop) begin
                       state_d = IDLE;
                       done    = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        word_perr = 1'b0;
        case (PARITY)
            1:       word_perr = ^shift_q ^ par_q;
            2:       word_perr = ~(^shift_q ^ par_q);
            3:       word_perr = ~par_q;
            4:       word_perr = par_q;
            default: word_perr = 1'b0;
        endcase
        word_ferr = stop_err_q | ~vote;
        word_brk  = stop_low_q & ~vote & (shift_q == '0) & ((PARITY == 0) | ~par_q);
    end

    always_comb begin
        sync_d      = {sync_q[0], rx};
        cnt_d       = (state_d == IDLE) ? '0 :
                      (cnt_q == CNT_W'(BIT_ - 1)) ? '0 : cnt_q + CNT_W'(1);
        s0_d        = (cnt_q == CNT_W'(HALF - 1)) ? rxs : s0_q;
        s1_d        = (cnt_q == CNT_W'(HALF))     ? rxs : s1_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_err_d  = stop_err_q;
        stop_low_d  = stop_low_q;
        wait_high_d = wait_high_q;

        if (state_q != state_d) idx_d = '0;
        else if (decide && (state_q == DATA || state_q == STOP)) idx_d = idx_q + IDX_W'(1);

        if (state_q == DATA && decide) shift_d = {vote, shift_q[DATA_-1:1]};
        if (state_q == PAR && decide)  par_d = vote;

        if (state_q == IDLE) begin
            stop_err_d = 1'b0;
            stop_low_d = 1'b1;
        end else if (state_q == STOP && decide) begin
            stop_err_d = stop_err_q | ~vote;
            stop_low_d = stop_low_q & ~vote;
        end

        // After a break the line must go idle again before a new start is armed.
        if (done && word_brk)          wait_high_d = 1'b1;
        else if (state_q == IDLE && rxs) wait_high_d = 1'b0;

        dout_d  = dout_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        valid_d = valid_q & ~bus.ready;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || bus.ready) begin
                dout_d  = shift_q;
                perr_d  = word_perr;
                ferr_d  = word_ferr;
                brk_d   = word_brk;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            stop_err_q  <= 1'b0;
            stop_low_q  <= 1'b1;
            wait_high_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            stop_err_q  <= stop_err_d;
            stop_low_q  <= stop_low_d;
            wait_high_q <= wait_high_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.brk        = brk_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench: one 8N1 instance and one 8E1 instance, line-level stimulus, word-level model.
module tb_uart_rx_frontend;
    localparam int BIT_ = 25;
    localparam int HALF = BIT_ / 2;
    localparam int DEC  = 9 * BIT_ + HALF + 1;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic busy0, busy1;

    uart_rx_frontend_if #(.DATA_(8)) bus0 ();
    uart_rx_frontend_if #(.DATA_(8)) bus1 ();

    uart_rx_frontend dut0 (.clk(clk), .rst_(rst_), .rx(rx0), .busy(busy0), .bus(bus0));
    uart_rx_frontend #(.PARITY(1)) dut1 (.clk(clk), .rst_(rst_), .rx(rx1), .busy(busy1), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    word_t cap0[$], cap1[$];
    int    cyc = 0;
    int    bit_start_cyc, frame_start;
    int    ovr_cnt0 = 0;
    int    rise_cyc0 = -1;
    logic  busy_at_rise0, busy_before_rise0;
    logic  valid0_prev = 1'b0, busy0_prev = 1'b0;
    bit    rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample just after the falling edge, when bench-driven inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (bus0.valid && bus0.ready) cap0.push_back({bus0.dout, bus0.parity_err, bus0.frame_err, bus0.brk});
        if (bus1.valid && bus1.ready) cap1.push_back({bus1.dout, bus1.parity_err, bus1.frame_err, bus1.brk});
        if (bus0.overrun) ovr_cnt0++;
        if (bus0.valid && !valid0_prev) begin
            rise_cyc0         = cyc;
            busy_at_rise0     = busy0;
            busy_before_rise0 = busy0_prev;
        end
        valid0_prev = bus0.valid;
        busy0_prev  = busy0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input int sel, input logic val, input int glitch_at);
        for (int k = 0; k < BIT_; k++) begin
            @(negedge clk);
            if (k == 0) bit_start_cyc = cyc;
            if (sel == 0) rx0 = (k == glitch_at) ? ~val : val;
            else          rx1 = (k == glitch_at) ? ~val : val;
            if (rand_rdy) begin
                bus0.ready = 1'($urandom_range(0, 1));
                bus1.ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                              input logic pbit, input logic stop_val, input int gbit, input int goff);
        drive_bit(sel, 1'b0, -1);
        frame_start = bit_start_cyc;
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], (i == gbit) ? goff : -1);
        if (has_par) drive_bit(sel, pbit, -1);
        drive_bit(sel, stop_val, -1);
        if (!stop_val) drive_bit(sel, 1'b1, -1);
    endtask

    task automatic wait_cap(input int sel, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 ? cap0.size() : cap1.size()) >= n) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_ = 1'b0;
        bus0.ready = 1'b1;
        bus1.ready = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus0.valid, bus0.dout, bus0.parity_err, bus0.frame_err, bus0.brk, bus0.overrun, busy0};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_dut0 got %h exp 0", got); end
        got = {bus1.valid, bus1.dout, bus1.parity_err, bus1.frame_err, bus1.brk, bus1.overrun, busy1};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_dut1 got %h exp 0", got); end
        rst_ = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || bus0.valid !== 1'b0) begin
            errors++; $display("FAIL reset_release busy=%b valid=%b exp 0 0", busy0, bus0.valid);
        end
    endtask

    task automatic test_basic();
        word_t w;
        int lat;
        cap0.delete();
        rise_cyc0 = -1;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 0);
        wait_cap(0, 1, 200);
        checks++;
        if (cap0.size() != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", cap0.size()); end
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'hA5, 3'b000}) begin errors++; $display("FAIL basic_word got %h exp %h", w, {8'hA5, 3'b000}); end
        lat = rise_cyc0 - frame_start;
        checks++;
        if (lat < DEC || lat > DEC + 3) begin errors++; $display("FAIL basic_latency got %0d exp %0d..%0d", lat, DEC, DEC + 3); end
        checks++;
        if (busy_at_rise0 !== 1'b0 || busy_before_rise0 !== 1'b1) begin
            errors++; $display("FAIL basic_busy_fall got %b%b exp 10", busy_before_rise0, busy_at_rise0);
        end
    endtask

    task automatic test_parity();
        word_t w;
        cap1.delete();
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, -1, 0);
        wait_cap(1, 1, 200);
        w = (cap1.size() > 0) ? cap1[0] : '1;
        checks++;
        if (w !== {8'h03, 3'b100}) begin errors++; $display("FAIL parity_bad got %h exp %h", w, {8'h03, 3'b100}); end
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, -1, 0);
        wait_cap(1, 2, 200);
        w = (cap1.size() > 1) ? cap1[1] : '1;
        checks++;
        if (w !== {8'h03, 3'b000}) begin errors++; $display("FAIL parity_good got %h exp %h", w, {8'h03, 3'b000}); end
    endtask

    task automatic test_framing();
        word_t w;
        int busy_hits;
        cap0.delete();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, -1, 0);
        wait_cap(0, 1, 200);
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'h5A, 3'b010}) begin errors++; $display("FAIL frame_err got %h exp %h", w, {8'h5A, 3'b010}); end
        repeat (2 * BIT_) @(negedge clk);
        cap0.delete();
        busy_hits = 0;
        for (int k = 0; k < 12 * BIT_; k++) begin
            @(negedge clk);
            rx0 = 1'b0;
            if (k >= DEC + 5 && busy0) busy_hits++;
        end
        checks++;
        if (busy_hits != 0) begin errors++; $display("FAIL break_rearm busy_cycles got %0d exp 0", busy_hits); end
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'h00, 3'b011} || cap0.size() != 1) begin
            errors++; $display("FAIL break_word got %h n=%0d exp %h n=1", w, cap0.size(), {8'h00, 3'b011});
        end
        @(negedge clk);
        rx0 = 1'b1;
        repeat (BIT_) @(negedge clk);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1, 0);
        wait_cap(0, 2, 200);
        w = (cap0.size() > 1) ? cap0[1] : '1;
        checks++;
        if (w !== {8'h81, 3'b000}) begin errors++; $display("FAIL break_recover got %h exp %h", w, {8'h81, 3'b000}); end
    endtask

    task automatic test_glitch();
        int lens[2];
        bit busy_seen;
        word_t w;
        lens = '{5, 11};
        cap0.delete();
        foreach (lens[j]) begin
            busy_seen = 1'b0;
            for (int k = 0; k < lens[j]; k++) begin
                @(negedge clk);
                rx0 = 1'b0;
                if (busy0) busy_seen = 1'b1;
            end
            for (int k = 0; k < 2 * BIT_; k++) begin
                @(negedge clk);
                rx0 = 1'b1;
                if (busy0) busy_seen = 1'b1;
            end
            checks++;
            if (!busy_seen || busy0 !== 1'b0 || cap0.size() != 0) begin
                errors++;
                $display("FAIL glitch_len%0d seen=%b busy=%b words=%0d exp 1 0 0", lens[j], busy_seen, busy0, cap0.size());
            end
        end
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 3, $urandom_range(HALF - 1, HALF + 1));
        wait_cap(0, 1, 200);
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'hFF, 3'b000} || cap0.size() != 1) begin
            errors++; $display("FAIL glitch_vote got %h n=%0d exp %h n=1", w, cap0.size(), {8'hFF, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        word_t w;
        cap0.delete();
        bus0.ready = 1'b0;
        ovr_cnt0 = 0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, 0);
        checks++;
        if (ovr_cnt0 != 0 || bus0.valid !== 1'b1) begin
            errors++; $display("FAIL ovr_first ovr=%0d valid=%b exp 0 1", ovr_cnt0, bus0.valid);
        end
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (ovr_cnt0 != 1) begin errors++; $display("FAIL ovr_pulse cycles got %0d exp 1", ovr_cnt0); end
        checks++;
        if (bus0.valid !== 1'b1 || bus0.dout !== 8'h11) begin
            errors++; $display("FAIL ovr_hold valid=%b dout=%h exp 1 11", bus0.valid, bus0.dout);
        end
        bus0.ready = 1'b1;
        wait_cap(0, 1, 20);
        repeat (3 * BIT_) @(negedge clk);
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'h11, 3'b000} || cap0.size() != 1 || bus0.valid !== 1'b0) begin
            errors++; $display("FAIL ovr_drain got %h n=%0d valid=%b exp %h n=1 valid=0", w, cap0.size(), bus0.valid, {8'h11, 3'b000});
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        logic [13:0] got;
        word_t w;
        d = 8'h77;
        cap0.delete();
        drive_bit(0, 1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], -1);
        for (int k = 0; k < HALF; k++) begin
            @(negedge clk);
            rx0 = d[4];
        end
        @(negedge clk);
        rst_ = 1'b0;
        rx0  = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus0.valid, bus0.dout, bus0.parity_err, bus0.frame_err, bus0.brk, bus0.overrun, busy0};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL midframe_reset got %h exp 0", got); end
        rst_ = 1'b1;
        repeat (2 * BIT_) @(negedge clk);
        checks++;
        if (cap0.size() != 0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL midframe_partial words=%0d busy=%b exp 0 0", cap0.size(), busy0);
        end
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
        wait_cap(0, 1, 200);
        w = (cap0.size() > 0) ? cap0[0] : '1;
        checks++;
        if (w !== {8'h3C, 3'b000} || cap0.size() != 1) begin
            errors++; $display("FAIL midframe_next got %h n=%0d exp %h n=1", w, cap0.size(), {8'h3C, 3'b000});
        end
    endtask

    task automatic test_random();
        word_t exp0[$], exp1[$];
        logic [7:0] d;
        logic stop_ok, p;
        cap0.delete();
        cap1.delete();
        rand_rdy = 1'b1;
        for (int n = 0; n < 12; n++) begin
            d       = (n == 5) ? 8'h00 : 8'($urandom);
            stop_ok = (n == 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            exp0.push_back({d, 1'b0, ~stop_ok, ~stop_ok && (d == 8'h00)});
            send_frame(0, d, 1'b0, 1'b0, stop_ok, $urandom_range(0, 7), $urandom_range(HALF - 1, HALF + 1));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            exp1.push_back({d, (^d) ^ p, 1'b0, 1'b0});
            send_frame(1, d, 1'b1, p, 1'b1, -1, 0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        rand_rdy = 1'b0;
        bus0.ready = 1'b1;
        bus1.ready = 1'b1;
        wait_cap(0, 12, 200);
        wait_cap(1, 8, 200);
        checks++;
        if (cap0.size() != 12 || cap1.size() != 8) begin
            errors++; $display("FAIL random_counts got %0d/%0d exp 12/8", cap0.size(), cap1.size());
        end
        foreach (exp0[i]) begin
            checks++;
            if (i >= cap0.size() || cap0[i] !== exp0[i]) begin
                errors++; $display("FAIL random_dut0_word%0d got %h exp %h", i, (i < cap0.size()) ? cap0[i] : '1, exp0[i]);
            end
        end
        foreach (exp1[i]) begin
            checks++;
            if (i >= cap1.size() || cap1[i] !== exp1[i]) begin
                errors++; $display("FAIL random_dut1_word%0d got %h exp %h", i, (i < cap1.size()) ? cap1[i] : '1, exp1[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
